axicb_scfifo_ctrl: RTL and testbench
====================================

Name: axicb_scfifo_ctrl

Overview:
- Single-clock FIFO controller for the AXI crossbar's channel buffers.
- Converts a valid/ready push interface and a valid/ready pull interface into write/read strobes and addresses for the dual-port storage array it instantiates.
- Tracks fill level and full/empty state.
- With registered RAM reads, it adds a one-entry prefetch stage so the output stays first-word-fall-through.

Parameters:
- ADDR_WIDTH, 8, log2 of RAM depth; RAM holds DEPTH = 2**ADDR_WIDTH entries.
- DATA_WIDTH, 8, payload width.
- FFD_EN, 0, 1 = storage array read is registered and the controller runs the prefetch stage; 0 = combinational read.
- AFULL_THRESH, 2**ADDR_WIDTH-1, almost-full level; used only with the optional feature.
- AEMPTY_THRESH, 1, almost-empty level; used only with the optional feature.

Ports:
- aclk  in  1  clock; all logic rising-edge.
- srst  in  1  synchronous reset, active-high.
- flush  in  1  synchronous clear of contents; same effect as srst on state.
- in_valid  in  1  push request.
- in_ready  out  1  push accepted when in_valid & in_ready.
- in_data  in  DATA_WIDTH  push payload.
- out_valid  out  1  head entry available.
- out_ready  in  1  pop when out_valid & out_ready.
- out_data  out  DATA_WIDTH  head payload; stable while out_valid & !out_ready.
- count  out  ADDR_WIDTH+1  total entries held (RAM plus prefetch register).
- afull  out  1  optional, count >= AFULL_THRESH.
- aempty  out  1  optional, count <= AEMPTY_THRESH.

Behaviour:
- Clock and reset: one clock aclk. Reset srst is synchronous, active-high.
- Pointers: wr_ptr and rd_ptr are ADDR_WIDTH+1 bits. The MSB is the wrap bit; the lower bits address the RAM.
  - ram_empty when pointers are equal.
  - ram_full when the lower bits are equal and the MSBs differ.
  - Pointers wrap naturally from DEPTH-1 to 0 with an MSB toggle.
- Reset/flush values: wr_ptr=0, rd_ptr=0, prefetch valid=0, in_ready=1, out_valid=0, count=0, afull=0, aempty=1.
  - out_data is don't-care while out_valid=0.
  - srst or flush mid-transfer discards all entries. Handshakes presented in that same cycle are ignored.
  - srst has priority over flush.
- Push side:
  - in_ready = !ram_full, registered-free; depends only on pointers, never on out_ready.
  - An accepted push drives RAM wr_en=1, addr_in=wr_ptr[ADDR_WIDTH-1:0], then increments wr_ptr.
- FFD_EN=0 (pop and latency):
  - out_valid = !ram_empty; out_data = RAM data_out with addr_out = rd_ptr.
  - A pop increments rd_ptr.
  - Push accepted at edge N gives out_valid high after edge N (next cycle); there is no same-cycle bypass.
  - Capacity is DEPTH.
- FFD_EN=1 (pop and latency):
  - Prefetch stage holds pf_vld; out_valid = pf_vld.
  - addr_out = rd_ptr lower bits. Load is asserted when !ram_empty & (!pf_vld | out_ready).
  - On load: rd_ptr increments and pf_vld is set at the edge; RAM registers data_out at the same edge.
  - On pop without load: pf_vld clears.
  - Push accepted at edge N gives out_valid after edge N+1.
  - Capacity is DEPTH+1; count = RAM occupancy + pf_vld.
- Simultaneous push and pop:
  - When full, in_ready=0, so only the pop occurs. in_ready rises the next cycle.
  - When RAM holds exactly 1 entry, push and pop both proceed and count is unchanged.
  - When empty, only the push is possible.
- Read-during-write to the same address cannot occur: reads only target occupied entries.
- out_data must not change while out_valid=1 and out_ready=0.

Optional Feature:
- Macro AXICB_SCFIFO_STATUS_EN.
- Defined: afull and aempty ports exist, computed combinationally from count against AFULL_THRESH and AEMPTY_THRESH (reset values as above).
- Undefined: the ports and their comparators are absent; the thresholds are ignored.

Decomposition:
- Shared package axicb_scfifo_pkg holds:
  - the pointer typedef (ADDR_WIDTH+1 bits, parameterised via function);
  - the localparam DEPTH helper;
  - the status-compare function.
- One sub-module: axicb_scfifo_ram, instantiated with the same ADDR_WIDTH, DATA_WIDTH and FFD_EN.
- Pointer and prefetch logic stays in this block.

Test Plan:
- Reset/flush: ADDR_WIDTH=2. Push 3 words, assert flush one cycle → count=0, out_valid=0, in_ready=1 the next cycle; srst asserted mid-burst gives the same result.
- Fill to full: ADDR_WIDTH=2, FFD_EN=0. Push 0xA0..0xA4 with out_ready=0 → 4 accepted, in_ready=0 after the 4th, 0xA4 held off. Drain → 0xA0..0xA3 in order.
- FFD_EN=1 latency and capacity: single push 0x55 at edge N → out_valid at N+2 with out_data=0x55. Fill with out_ready=0 → 5 entries accepted, count=5.
- Simultaneous push/pop at full: FFD_EN=0, full, in_valid=out_ready=1 for one cycle → pop occurs, push rejected, count goes 4→3; push accepted the following cycle.
- Wrap-around: ADDR_WIDTH=2. Stream 20 words (0..19) with random in_valid/out_ready at 50% → output sequence 0..19 exact, no loss or duplication, count never exceeds 4 (FFD_EN=0) or 5 (FFD_EN=1).
- Status (macro defined): AFULL_THRESH=3, AEMPTY_THRESH=1. Push to count=3 → afull=1; pop to count=1 → aempty=1, afull=0.

Source files
------------

// File: rtl/axicb_scfifo_pkg.sv
// Shared types and helpers for the crossbar single-clock FIFO controller.
// Pointer sizing, depth and status comparison live here so every file agrees.
package axicb_scfifo_pkg;

   typedef struct packed {
      logic afull;
      logic aempty;
   } status_t;

   // One extra MSB on each pointer distinguishes full from empty.
   function automatic int unsigned ptr_width(input int unsigned addr_width);
      return addr_width + 1;
   endfunction

   function automatic int unsigned depth_of(input int unsigned addr_width);
      return 1 << addr_width;
   endfunction

   function automatic status_t status_cmp(input int unsigned level,
                                          input int unsigned afull_th,
                                          input int unsigned aempty_th);
      status_t s;
      s.afull  = (level >= afull_th);
      s.aempty = (level <= aempty_th);
      return s;
   endfunction

endpackage

// File: rtl/axicb_scfifo_ctrl_if.sv
// Push/pull valid-ready bundle of the FIFO; slave is the FIFO's own view.
interface axicb_scfifo_ctrl_if #(
   parameter int unsigned DATA_WIDTH = 8
);
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );
endinterface

// File: rtl/axicb_scfifo_ram.sv
// Simple dual-port storage array; FFD_EN selects registered or combinational read.
module axicb_scfifo_ram
   import axicb_scfifo_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned FFD_EN     = 0
) (
   input  logic                  aclk,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] addr_in,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] addr_out,
   output logic [DATA_WIDTH-1:0] data_out
);
   localparam int unsigned DEPTH = depth_of(ADDR_WIDTH);

   logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

   always_ff @(posedge aclk) begin
      if (wr_en) mem[addr_in] <= data_in;
   end

   generate
      if (FFD_EN != 0) begin : g_reg_rd
         // Output register only moves on rd_en, so the held word stays put under backpressure.
         always_ff @(posedge aclk) begin
            if (rd_en) data_out <= mem[addr_out];
         end
      end else begin : g_comb_rd
         assign data_out = rd_en ? mem[addr_out] : '0;
      end
   endgenerate

endmodule

// File: rtl/axicb_scfifo_ctrl.sv
// Single-clock FIFO controller with optional prefetch stage for registered RAM reads.
// Define AXICB_SCFIFO_STATUS_EN to add the afull/aempty status outputs.
module axicb_scfifo_ctrl
   import axicb_scfifo_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH    = 8,
   parameter int unsigned DATA_WIDTH    = 8,
   parameter int unsigned FFD_EN        = 0,
   parameter int unsigned AFULL_THRESH  = (1 << ADDR_WIDTH) - 1,
   parameter int unsigned AEMPTY_THRESH = 1
) (
   input  logic                aclk,
   input  logic                srst,
   input  logic                flush,
   axicb_scfifo_ctrl_if.slave  bus,
   output logic [ADDR_WIDTH:0] count
`ifdef AXICB_SCFIFO_STATUS_EN
  ,output logic                afull,
   output logic                aempty
`endif
);
   typedef logic [ptr_width(ADDR_WIDTH)-1:0] ptr_t;
   localparam ptr_t PTR_ONE = ptr_t'(1);

   ptr_t                  wr_ptr;
   ptr_t                  rd_ptr;
   logic                  clr;
   logic                  ram_empty;
   logic                  ram_full;
   logic                  push;
   logic                  load;
   logic                  ram_rd_en;
   logic                  pf_vld;
   logic [DATA_WIDTH-1:0] ram_dout;

   assign clr       = srst | flush;
   assign ram_empty = (wr_ptr == rd_ptr);
   assign ram_full  = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                      (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);

   assign bus.in_ready = !ram_full;
   assign push         = bus.in_valid & !ram_full & !clr;

   generate
      if (FFD_EN != 0) begin : g_prefetch
         // RAM word moves into the prefetch slot whenever the slot is free or being emptied.
         assign load      = !ram_empty & (!pf_vld | bus.out_ready) & !clr;
         assign ram_rd_en = load;

         always_ff @(posedge aclk) begin
            if (clr)                 pf_vld <= 1'b0;
            else if (load)           pf_vld <= 1'b1;
            else if (bus.out_ready)  pf_vld <= 1'b0;
         end

         assign bus.out_valid = pf_vld;
      end else begin : g_direct
         assign pf_vld        = 1'b0;
         assign load          = !ram_empty & bus.out_ready & !clr;
         assign ram_rd_en     = !ram_empty;
         assign bus.out_valid = !ram_empty;
      end

      if (AEMPTY_THRESH > AFULL_THRESH) begin : g_bad_thresh
         $error("axicb_scfifo_ctrl: AEMPTY_THRESH above AFULL_THRESH");
      end
   endgenerate

   always_ff @(posedge aclk) begin
      if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (load) rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   assign count        = (wr_ptr - rd_ptr) + {{ADDR_WIDTH{1'b0}}, pf_vld};
   assign bus.out_data = ram_dout;

`ifdef AXICB_SCFIFO_STATUS_EN
   status_t status;
   assign status = status_cmp(32'(count), AFULL_THRESH, AEMPTY_THRESH);
   assign afull  = status.afull;
   assign aempty = status.aempty;
`endif

   axicb_scfifo_ram #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .FFD_EN     (FFD_EN)
   ) u_ram (
      .aclk     (aclk),
      .wr_en    (push),
      .addr_in  (wr_ptr[ADDR_WIDTH-1:0]),
      .data_in  (bus.in_data),
      .rd_en    (ram_rd_en),
      .addr_out (rd_ptr[ADDR_WIDTH-1:0]),
      .data_out (ram_dout)
   );

endmodule

// File: tb/tb_axicb_scfifo_ctrl.sv
// Directed bench for axicb_scfifo_ctrl: one FFD_EN=0 and one FFD_EN=1 instance, depth 4.
module tb_axicb_scfifo_ctrl;

   logic aclk = 1'b0;
   logic srst;
   logic flush;
   always #5 aclk = ~aclk;

   int unsigned checks = 0;
   int unsigned errors = 0;

   axicb_scfifo_ctrl_if #(.DATA_WIDTH(8)) b0 ();
   axicb_scfifo_ctrl_if #(.DATA_WIDTH(8)) b1 ();
   logic [2:0] count0;
   logic [2:0] count1;
`ifdef AXICB_SCFIFO_STATUS_EN
   logic afull0, aempty0, afull1, aempty1;
`endif

   axicb_scfifo_ctrl #(
      .ADDR_WIDTH(2), .DATA_WIDTH(8), .FFD_EN(0), .AFULL_THRESH(3), .AEMPTY_THRESH(1)
   ) u0 (
      .aclk(aclk), .srst(srst), .flush(flush), .bus(b0), .count(count0)
`ifdef AXICB_SCFIFO_STATUS_EN
     ,.afull(afull0), .aempty(aempty0)
`endif
   );

   axicb_scfifo_ctrl #(
      .ADDR_WIDTH(2), .DATA_WIDTH(8), .FFD_EN(1), .AFULL_THRESH(3), .AEMPTY_THRESH(1)
   ) u1 (
      .aclk(aclk), .srst(srst), .flush(flush), .bus(b1), .count(count1)
`ifdef AXICB_SCFIFO_STATUS_EN
     ,.afull(afull1), .aempty(aempty1)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic idle();
      b0.in_valid = 1'b0; b0.in_data = '0; b0.out_ready = 1'b0;
      b1.in_valid = 1'b0; b1.in_data = '0; b1.out_ready = 1'b0;
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_cnt0"}, 32'(count0), 0);
      check({tag, "_ov0"}, 32'(b0.out_valid), 0);
      check({tag, "_ir0"}, 32'(b0.in_ready), 1);
      check({tag, "_cnt1"}, 32'(count1), 0);
      check({tag, "_ov1"}, 32'(b1.out_valid), 0);
      check({tag, "_ir1"}, 32'(b1.in_ready), 1);
   endtask

   int unsigned sent0, recv0, sent1, recv1;
   logic        hold0, hold1;
   logic [7:0]  held0, held1;

   initial begin
      idle();
      srst = 1'b1;
      flush = 1'b0;
      tick();
      tick();
      srst = 1'b0;
      check_cleared("reset");
`ifdef AXICB_SCFIFO_STATUS_EN
      check("reset_afull0", 32'(afull0), 0);
      check("reset_aempty0", 32'(aempty0), 1);
`endif

      // flush with three words held; handshakes in the flush cycle are dropped
      b0.in_valid = 1'b1; b1.in_valid = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         b0.in_data = 8'(i); b1.in_data = 8'(i);
         tick();
      end
      idle();
      check("pre_flush_cnt0", 32'(count0), 3);
      check("pre_flush_cnt1", 32'(count1), 3);
      check("pre_flush_dat0", 32'(b0.out_data), 1);
      check("pre_flush_dat1", 32'(b1.out_data), 1);
      flush = 1'b1;
      b0.in_valid = 1'b1; b0.out_ready = 1'b1; b1.in_valid = 1'b1; b1.out_ready = 1'b1;
      tick();
      flush = 1'b0;
      idle();
      check_cleared("flush");

      // srst mid-burst
      b0.in_valid = 1'b1; b1.in_valid = 1'b1;
      b0.in_data = 8'h07; b1.in_data = 8'h07; tick();
      b0.in_data = 8'h08; b1.in_data = 8'h08; tick();
      b0.in_data = 8'h09; b1.in_data = 8'h09;
      srst = 1'b1;
      tick();
      srst = 1'b0;
      idle();
      check_cleared("srst");

      // fill FFD_EN=0 to full, fifth word held off
      for (int i = 0; i < 5; i++) begin
         b0.in_valid = 1'b1;
         b0.in_data = 8'(8'hA0 + i);
         check("fill_ready0", 32'(b0.in_ready), (i < 4) ? 1 : 0);
         tick();
      end
      idle();
      check("fill_cnt0", 32'(count0), 4);
      check("fill_ir0", 32'(b0.in_ready), 0);
      b0.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("drain_ov0", 32'(b0.out_valid), 1);
         check("drain_dat0", 32'(b0.out_data), 32'(8'hA0 + i));
         tick();
      end
      idle();
      check("drain_empty0", 32'(b0.out_valid), 0);
      check("drain_cnt0", 32'(count0), 0);

      // FFD_EN=1 latency: visible one cycle after the push edge
      b1.in_valid = 1'b1; b1.in_data = 8'h55;
      tick();
      idle();
      check("lat_ov1_n", 32'(b1.out_valid), 0);
      check("lat_cnt1_n", 32'(count1), 1);
      tick();
      check("lat_ov1_n1", 32'(b1.out_valid), 1);
      check("lat_dat1", 32'(b1.out_data), 32'h55);
      b1.out_ready = 1'b1;
      tick();
      idle();
      check("lat_pop_ov1", 32'(b1.out_valid), 0);
      check("lat_pop_cnt1", 32'(count1), 0);

      // FFD_EN=1 capacity is DEPTH+1
      for (int i = 0; i < 6; i++) begin
         b1.in_valid = 1'b1;
         b1.in_data = 8'(8'hB0 + i);
         check("cap_ready1", 32'(b1.in_ready), (i < 5) ? 1 : 0);
         tick();
      end
      idle();
      check("cap_cnt1", 32'(count1), 5);
      check("cap_ir1", 32'(b1.in_ready), 0);
      b1.out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check("cap_ov1", 32'(b1.out_valid), 1);
         check("cap_dat1", 32'(b1.out_data), 32'(8'hB0 + i));
         tick();
      end
      idle();
      check("cap_empty1", 32'(b1.out_valid), 0);
      check("cap_cnt1_end", 32'(count1), 0);

      // simultaneous push/pop when full: only the pop happens
      for (int i = 0; i < 4; i++) begin
         b0.in_valid = 1'b1;
         b0.in_data = 8'(8'hC0 + i);
         tick();
      end
      b0.in_data = 8'hC4;
      b0.out_ready = 1'b1;
      check("full_pp_ir0", 32'(b0.in_ready), 0);
      check("full_pp_dat0", 32'(b0.out_data), 32'hC0);
      tick();
      b0.out_ready = 1'b0;
      check("full_pp_cnt0", 32'(count0), 3);
      check("full_pp_ir0_next", 32'(b0.in_ready), 1);
      tick();
      idle();
      check("full_pp_cnt0_refill", 32'(count0), 4);
      b0.out_ready = 1'b1;
      for (int i = 1; i < 5; i++) begin
         check("full_pp_drain0", 32'(b0.out_data), 32'(8'hC0 + i));
         tick();
      end
      idle();
      check("full_pp_empty0", 32'(b0.out_valid), 0);

      // one entry held: push and pop both proceed
      b0.in_valid = 1'b1; b0.in_data = 8'hD0;
      tick();
      b0.in_data = 8'hD1; b0.out_ready = 1'b1;
      check("one_pp_dat0", 32'(b0.out_data), 32'hD0);
      tick();
      idle();
      check("one_pp_cnt0", 32'(count0), 1);
      check("one_pp_dat0_next", 32'(b0.out_data), 32'hD1);
      b0.out_ready = 1'b1;
      tick();
      idle();
      check("one_pp_empty0", 32'(b0.out_valid), 0);

`ifdef AXICB_SCFIFO_STATUS_EN
      b0.in_valid = 1'b1; b0.in_data = 8'hE0;
      tick();
      check("st_c1_aempty", 32'(aempty0), 1);
      check("st_c1_afull", 32'(afull0), 0);
      b0.in_data = 8'hE1; tick();
      b0.in_data = 8'hE2; tick();
      idle();
      check("st_c3_afull", 32'(afull0), 1);
      check("st_c3_aempty", 32'(aempty0), 0);
      b0.out_ready = 1'b1;
      tick();
      tick();
      idle();
      check("st_pop_cnt", 32'(count0), 1);
      check("st_pop_aempty", 32'(aempty0), 1);
      check("st_pop_afull", 32'(afull0), 0);
      b0.out_ready = 1'b1;
      tick();
      idle();
`endif

      // random streaming through the wrap point on both instances
      sent0 = 0; recv0 = 0; sent1 = 0; recv1 = 0;
      hold0 = 1'b0; hold1 = 1'b0; held0 = '0; held1 = '0;
      for (int cyc = 0; cyc < 400 && (recv0 < 20 || recv1 < 20); cyc++) begin
         b0.in_valid  = (sent0 < 20) && ($urandom_range(0, 1) == 1);
         b0.in_data   = 8'(sent0);
         b0.out_ready = ($urandom_range(0, 1) == 1);
         b1.in_valid  = (sent1 < 20) && ($urandom_range(0, 1) == 1);
         b1.in_data   = 8'(sent1);
         b1.out_ready = ($urandom_range(0, 1) == 1);
         #1;
         if (hold0) check("hold_dat0", {23'b0, b0.out_valid, b0.out_data}, {23'b0, 1'b1, held0});
         if (hold1) check("hold_dat1", {23'b0, b1.out_valid, b1.out_data}, {23'b0, 1'b1, held1});
         hold0 = b0.out_valid && !b0.out_ready; held0 = b0.out_data;
         hold1 = b1.out_valid && !b1.out_ready; held1 = b1.out_data;
         if (b0.out_valid && b0.out_ready) begin
            check("wrap_dat0", 32'(b0.out_data), recv0);
            recv0++;
         end
         if (b1.out_valid && b1.out_ready) begin
            check("wrap_dat1", 32'(b1.out_data), recv1);
            recv1++;
         end
         if (b0.in_valid && b0.in_ready) sent0++;
         if (b1.in_valid && b1.in_ready) sent1++;
         tick();
         check("wrap_max0", 32'(count0 <= 3'd4), 1);
         check("wrap_max1", 32'(count1 <= 3'd5), 1);
      end
      idle();
      check("wrap_recv0", recv0, 20);
      check("wrap_recv1", recv1, 20);
      check("wrap_end_cnt0", 32'(count0), 0);
      check("wrap_end_cnt1", 32'(count1), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
